alu_pipe: RTL and testbench

Parametrised, registered successor to the 4-bit combinational ALU. It accepts one operation per valid/ready handshake and returns a registered result with status flags. All single-cycle ops complete in one clock. The multiply op runs as a multi-cycle shift-add state machine. It sits between the operand/op source and any result consumer, and it tolerates backpressure on the output.

---
 rtl/alu_pipe.sv | 170 +++++++++++++++++
 tb/tb_alu_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake, status flags and output backpressure.
// Define ALU_MUL_EN to make op 111 a multi-cycle shift-add unsigned multiply (MUL_BUSY state).
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic               w_accept;
    logic               w_start_mul;
    logic               w_load_single;
    logic               w_load_mul;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [2*WIDTH-1:0] w_mul_prod;

    // The extra top bit of the difference is the unsigned borrow.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latch is inferred.
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_SHL: begin
                w_res = {a[WIDTH-2:0], 1'b0};
                w_c   = a[WIDTH-1];
            end
            default: w_res = '0;
        endcase
    end

    assign w_accept      = in_valid && in_ready;
    assign w_load_single = w_accept && !w_start_mul;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            out_valid  <= 1'b0;
            alu_out    <= '0;
            alu_out_hi <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
        end else if (w_load_single) begin
            out_valid  <= 1'b1;
            alu_out    <= w_res;
            alu_out_hi <= '0;
            flag_z     <= (w_res == '0);
            flag_c     <= w_c;
            flag_n     <= w_res[WIDTH-1];
            flag_v     <= w_v;
        end else if (w_load_mul) begin
            out_valid  <= 1'b1;
            alu_out    <= w_mul_prod[WIDTH-1:0];
            alu_out_hi <= w_mul_prod[2*WIDTH-1:WIDTH];
            flag_z     <= (w_mul_prod == '0);
            flag_c     <= (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
            flag_n     <= w_mul_prod[WIDTH-1];
            flag_v     <= 1'b0;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ALU_MUL_EN
    typedef enum logic {
        S_IDLE,
        S_MUL_BUSY
    } state_t;

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last_step;

    assign w_start_mul = w_accept && (op == OP_MUL);
    assign w_last_step = (r_state == S_MUL_BUSY) && (r_cnt == CNT_W'(1));
    assign w_load_mul  = w_last_step;
    assign w_mul_prod  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign in_ready    = (r_state == S_IDLE) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start_mul) w_state_next = S_MUL_BUSY;
            S_MUL_BUSY: if (w_last_step) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // NOTE: the multiply datapath has no reset; it is always loaded on accept before it is read.
    always_ff @(posedge clk) begin
        if (w_start_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (r_state == S_MUL_BUSY) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_mul_prod;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end
`else
    // Without the multiplier, op 111 is an ordinary single-cycle op that yields zero.
    assign w_start_mul = 1'b0;
    assign w_load_mul  = 1'b0;
    assign w_mul_prod  = '0;
    assign in_ready    = !out_valid || out_ready;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=4); directed scenarios plus randomized
// traffic with random output backpressure, checked against an arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] alu_out;
    logic [W-1:0] alu_out_hi;
    logic         flag_z, flag_c, flag_n, flag_v;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .alu_out_hi (alu_out_hi),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_n     (flag_n),
        .flag_v     (flag_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [3:0] lo;
        logic [3:0] hi;
        logic       z;
        logic       c;
        logic       n;
        logic       v;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rand_bp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [2:0] o, input int ua, input int ub);
        exp_t e;
        int   r;
        int   sa;
        int   sb;
        int   prod;
        e  = '0;
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        case (o)
            3'd0: begin
                r    = ua + ub;
                e.lo = 4'(r & 15);
                e.c  = (r > 15);
                e.v  = (sa + sb > 7) || (sa + sb < -8);
            end
            3'd1: begin
                r    = ua - ub;
                e.lo = 4'(r & 15);
                e.c  = (ua < ub);
                e.v  = (sa - sb > 7) || (sa - sb < -8);
            end
            3'd2: e.lo = 4'(ua & ub);
            3'd3: e.lo = 4'(ua | ub);
            3'd4: e.lo = 4'(ua ^ ub);
            3'd5: e.lo = 4'(15 - ua);
            3'd6: begin
                e.lo = 4'((ua * 2) & 15);
                e.c  = (ua >= 8);
            end
            default: begin
`ifdef ALU_MUL_EN
                prod = ua * ub;
                e.lo = 4'(prod % 16);
                e.hi = 4'(prod / 16);
                e.c  = (prod >= 16);
`else
                prod = 0;
`endif
            end
        endcase
        e.z = (e.lo == 4'd0) && (e.hi == 4'd0);
        e.n = (e.lo >= 4'd8);
        return e;
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks hold stability under backpressure.
    exp_t mon_got;
    exp_t mon_exp;
    exp_t hold_val;
    bit   hold_pend = 1'b0;

    always @(negedge clk) begin
        mon_got = {alu_out, alu_out_hi, flag_z, flag_c, flag_n, flag_v};
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) check("hold_stable", {out_valid, mon_got}, {1'b1, hold_val});
            hold_pend = out_valid && !out_ready;
            hold_val  = mon_got;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got %0h with nothing expected (t=%0t)", mon_got, $time);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("result", mon_got, mon_exp);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic issue(input logic [2:0] o, input logic [3:0] aa, input logic [3:0] bb);
        bit done;
        done     = 1'b0;
        op       = o;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
        end
        if (done) begin
            sb_q.push_back(model(o, int'(aa), int'(bb)));
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: op %0d never accepted", o);
        end
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state",
              {out_valid, alu_out, alu_out_hi, flag_z, flag_c, flag_n, flag_v, in_ready},
              {1'b0, 4'h0, 4'h0, 4'b0000, 1'b1});
        @(posedge clk);
        #1;

        // Ops 000..110 back-to-back with a=0011, b=0001: one accept per clock.
        t0 = cyc;
        for (int i = 0; i < 7; i++) issue(3'(i), 4'b0011, 4'b0001);
        check("throughput_cycles", cyc - t0, 7);
        @(negedge clk);
        check("shl_result", {out_valid, alu_out}, {1'b1, 4'b0110});
        @(posedge clk);
        #1;

        issue(3'b000, 4'b0111, 4'b0001);
        @(negedge clk);
        check("add_overflow", {alu_out, flag_z, flag_c, flag_n, flag_v}, {4'b1000, 4'b0011});
        @(posedge clk);
        #1;
        issue(3'b001, 4'b0001, 4'b0010);
        @(negedge clk);
        check("sub_borrow", {alu_out, flag_z, flag_c, flag_n, flag_v}, {4'b1111, 4'b0110});
        @(posedge clk);
        #1;

`ifdef ALU_MUL_EN
        issue(3'b111, 4'b1111, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mul_busy", {in_ready, out_valid}, 2'b00);
        end
        @(negedge clk);
        check("mul_ff", {out_valid, alu_out_hi, alu_out, flag_c}, {1'b1, 4'b1110, 4'b0001, 1'b1});
        @(posedge clk);
        #1;
        issue(3'b111, 4'b0000, 4'b1010);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mul_zero", {out_valid, alu_out_hi, alu_out, flag_z}, {1'b1, 4'h0, 4'h0, 1'b1});
        @(posedge clk);
        #1;
`else
        issue(3'b111, 4'b0011, 4'b0001);
        @(negedge clk);
        check("mul_disabled",
              {out_valid, alu_out_hi, alu_out, flag_z, flag_c, flag_n, flag_v},
              {1'b1, 4'h0, 4'h0, 4'b1000});
        @(posedge clk);
        #1;
`endif

        // Backpressure: result held for 3 cycles while a new request waits.
        out_ready = 1'b0;
        issue(3'b000, 4'b0011, 4'b0001);
        op       = 3'b001;
        a        = 4'b0101;
        b        = 4'b0010;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, in_ready, alu_out}, {1'b1, 1'b0, 4'b0100});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready", in_ready, 1);
        @(posedge clk);
        sb_q.push_back(model(3'b001, 5, 2));
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_new_result", {out_valid, alu_out}, {1'b1, 4'b0011});
        @(posedge clk);
        #1;

        // Reset two cycles into a multiply.
        issue(3'b111, 4'b1111, 4'b1111);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_abort", {out_valid, alu_out, in_ready}, {1'b0, 4'h0, 1'b1});
        @(posedge clk);
        #1;
        issue(3'b000, 4'b0011, 4'b0001);
        @(negedge clk);
        check("post_rst_add", {out_valid, alu_out}, {1'b1, 4'b0100});
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        rand_bp = 1'b1;
        repeat (300) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
